// File: rtl/qed_dup_scheduler_if.sv
// Handshake bundle between the instruction source, the QED duplication scheduler and the core front end.
interface qed_dup_scheduler_if #(
  parameter int unsigned INSN_LEN = 32
);
  logic                qed_enable;
  logic                qed_drain;
  logic [INSN_LEN-1:0] in_instruction;
  logic                in_valid;
  logic                in_ready;
  logic [INSN_LEN-1:0] out_instruction;
  logic                out_valid;
  logic                out_ready;
  logic                out_is_dup;
  logic                qed_sync;
  logic                illegal_insn;

  modport master (
    output qed_enable, qed_drain, in_instruction, in_valid, out_ready,
    input  in_ready, out_instruction, out_valid, out_is_dup, qed_sync, illegal_insn
  );

  modport slave (
    input  qed_enable, qed_drain, in_instruction, in_valid, out_ready,
    output in_ready, out_instruction, out_valid, out_is_dup, qed_sync, illegal_insn
  );
endinterface

// File: rtl/qed_dup_scheduler.sv
// EDDI-V style scheduler: issues a block of LW/SW/ADD originals, then replays them
// remapped onto x13..x25 (memory base x25) and pulses qed_sync when the block is closed.
module qed_dup_scheduler #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned INSN_LEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  qed_dup_scheduler_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  typedef enum logic {
    ORIG = 1'b0,
    DUP  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                mode_q, mode_d;
  logic [INSN_LEN-1:0] mem_q [DEPTH];

  logic [INSN_LEN-1:0] out_insn_q, out_insn_d;
  logic                out_valid_q, out_valid_d;
  logic                out_dup_q, out_dup_d;
  logic                out_last_q, out_last_d;
  logic                illegal_q, illegal_d;

  logic adv, in_ready, fire, push, pop, legal;

  function automatic logic [INSN_LEN-1:0] remap(input logic [INSN_LEN-1:0] i);
    logic [INSN_LEN-1:0] r;
    r = i;
    case (i[6:0])
      OP_ALU: begin
        r[11:7]  = i[11:7]  + 5'd13;
        r[19:15] = i[19:15] + 5'd13;
        r[24:20] = i[24:20] + 5'd13;
      end
      OP_LOAD: begin
        r[11:7] = i[11:7] + 5'd13;
        if (i[19:15] == 5'd0) r[19:15] = 5'd25;
      end
      OP_STORE: begin
        r[24:20] = i[24:20] + 5'd13;
        if (i[19:15] == 5'd0) r[19:15] = 5'd25;
      end
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    legal = 1'b0;
    case (bus.in_instruction[6:0])
      OP_LOAD:  legal = (bus.in_instruction[14:12] == 3'b010);
      OP_STORE: legal = (bus.in_instruction[14:12] == 3'b010);
      OP_ALU:   legal = (bus.in_instruction[14:12] == 3'b000) &&
                        (bus.in_instruction[31:25] == 7'b0);
      default:  legal = 1'b0;
    endcase
  end

  // The mode is only re-evaluated at a block boundary; the sampled value governs this cycle too.
  assign mode_d = (state_q == ORIG && count_q == '0) ? bus.qed_enable : mode_q;
  assign adv    = !out_valid_q || bus.out_ready;

  always_comb begin
    if (!mode_d)              in_ready = adv;
    else if (state_q == ORIG) in_ready = adv && (count_q < FULL);
    else                      in_ready = 1'b0;
  end

  assign fire = bus.in_valid && in_ready;
  assign push = mode_d && (state_q == ORIG) && fire && legal;
  assign pop  = (state_q == DUP) && adv;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ORIG: if (mode_d && (count_d == FULL || (bus.qed_drain && count_d != '0))) state_d = DUP;
      DUP:  if (pop && count_q == CW'(1)) state_d = ORIG;
      default: state_d = ORIG;
    endcase
  end

  always_comb begin
    out_insn_d  = out_insn_q;
    out_valid_d = out_valid_q;
    out_dup_d   = out_dup_q;
    out_last_d  = out_last_q;
    illegal_d   = fire && mode_d && !legal;
    if (adv) begin
      out_valid_d = 1'b0;
      out_dup_d   = 1'b0;
      out_last_d  = 1'b0;
      if (pop) begin
        out_insn_d  = remap(mem_q[rd_ptr_q]);
        out_valid_d = 1'b1;
        out_dup_d   = 1'b1;
        out_last_d  = (count_q == CW'(1));
      end else if (fire) begin
        out_insn_d  = bus.in_instruction;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_instruction;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ORIG;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      out_insn_q  <= '0;
      out_valid_q <= 1'b0;
      out_dup_q   <= 1'b0;
      out_last_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      out_insn_q  <= out_insn_d;
      out_valid_q <= out_valid_d;
      out_dup_q   <= out_dup_d;
      out_last_q  <= out_last_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_instruction = out_insn_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_is_dup      = out_dup_q;
  assign bus.qed_sync        = out_valid_q && bus.out_ready && out_last_q;
  assign bus.illegal_insn    = illegal_q;
endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Directed bench for qed_dup_scheduler: expected originals/duplicates queued on issue, checked on acceptance.
module tb_qed_dup_scheduler;
  logic clk;
  logic rst_n;

  qed_dup_scheduler_if #(.INSN_LEN(32)) bus ();

  qed_dup_scheduler #(.DEPTH(8), .INSN_LEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        dup;
    logic        sync;
  } exp_t;

  exp_t sbq[$];
  exp_t pend[$];
  int   checks   = 0;
  int   errors   = 0;
  int   sync_cnt = 0;
  bit   qmode    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("out_insn", bus.out_instruction, e.ins);
        chk("out_is_dup", {31'b0, bus.out_is_dup}, {31'b0, e.dup});
        chk("qed_sync", {31'b0, bus.qed_sync}, {31'b0, e.sync});
        if (bus.qed_sync) sync_cnt++;
      end
    end else begin
      chk("sync_idle", {31'b0, bus.qed_sync}, 32'd0);
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_block();
    exp_t e;
    for (int i = 0; i < pend.size(); i++) begin
      e      = pend[i];
      e.sync = (i == pend.size() - 1);
      sbq.push_back(e);
    end
    pend.delete();
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] dexp, input bit legal);
    bit   fired;
    exp_t e;
    fired = 1'b0;
    bus.in_instruction = ins;
    bus.in_valid       = 1'b1;
    for (int n = 0; n < 50 && !fired; n++) begin
      #1;
      if (bus.in_ready) begin
        fired  = 1'b1;
        e.ins  = ins;
        e.dup  = 1'b0;
        e.sync = 1'b0;
        sbq.push_back(e);
        if (qmode && legal) begin
          e.ins = dexp;
          e.dup = 1'b1;
          pend.push_back(e);
          if (pend.size() == 8) flush_block();
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", {31'b0, fired}, 32'd1);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  logic [31:0] ins_v;
  logic [31:0] dup_v;

  initial begin
    rst_n              = 1'b0;
    bus.qed_enable     = 1'b0;
    bus.qed_drain      = 1'b0;
    bus.in_instruction = '0;
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_insn", bus.out_instruction, 32'd0);
    chk("rst_out_is_dup", {31'b0, bus.out_is_dup}, 32'd0);
    chk("rst_qed_sync", {31'b0, bus.qed_sync}, 32'd0);
    chk("rst_illegal", {31'b0, bus.illegal_insn}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Bypass: pass-through with one cycle latency
    send(32'h003100B3, 32'h0, 1'b1);
    chk("bypass_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bypass_insn", bus.out_instruction, 32'h003100B3);
    chk("bypass_is_dup", {31'b0, bus.out_is_dup}, 32'd0);
    wait_empty();
    chk("bypass_no_sync", 32'(sync_cnt), 32'd0);

    bus.qed_enable = 1'b1;
    qmode          = 1'b1;
    tick();

    // Full block of identical ADDs
    for (int k = 0; k < 8; k++) send(32'h003100B3, 32'h01078733, 1'b1);
    bus.in_instruction = 32'h003100B3;
    bus.in_valid       = 1'b1;
    #1;
    chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    wait_empty();
    chk("sync_after_block", 32'(sync_cnt), 32'd1);
    chk("orig_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Partial blocks via drain: LW then SW
    send(32'h00402283, 32'h004CA903, 1'b1);
    bus.qed_drain = 1'b1;
    tick();
    bus.qed_drain = 1'b0;
    flush_block();
    wait_empty();
    chk("sync_after_lw", 32'(sync_cnt), 32'd2);

    send(32'h00302423, 32'h010CA423, 1'b1);
    bus.qed_drain = 1'b1;
    tick();
    bus.qed_drain = 1'b0;
    flush_block();
    wait_empty();
    chk("sync_after_sw", 32'(sync_cnt), 32'd3);

    // Distinct rd per entry, then stall mid-replay
    for (int rd = 1; rd <= 8; rd++) begin
      ins_v = 32'h00310033 | 32'(rd << 7);
      dup_v = 32'h01078033 | 32'((rd + 13) << 7);
      send(ins_v, dup_v, 1'b1);
    end
    repeat (3) tick();
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_hold", bus.out_instruction, sbq[0].ins);
      chk("stall_is_dup", {31'b0, bus.out_is_dup}, 32'd1);
      tick();
    end
    chk("stall_depth", 32'(sbq.size()), 32'd6);
    bus.out_ready = 1'b1;
    wait_empty();
    chk("sync_after_stall", 32'(sync_cnt), 32'd4);

    // Unconstrained instruction, then drain with an empty FIFO
    send(32'h00000013, 32'h0, 1'b0);
    chk("illegal_pulse", {31'b0, bus.illegal_insn}, 32'd1);
    chk("illegal_fwd", bus.out_instruction, 32'h00000013);
    tick();
    chk("illegal_clear", {31'b0, bus.illegal_insn}, 32'd0);
    bus.qed_drain = 1'b1;
    repeat (2) tick();
    bus.qed_drain = 1'b0;
    chk("empty_drain_orig", {31'b0, bus.in_ready}, 32'd1);
    wait_empty();

    // Reset with three originals buffered
    for (int rd = 1; rd <= 3; rd++) send(32'h00310033 | 32'(rd << 7), 32'h0, 1'b1);
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("async_rst_insn", bus.out_instruction, 32'd0);
    sbq.delete();
    pend.delete();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int rd = 1; rd <= 7; rd++) begin
      ins_v = 32'h00310033 | 32'(rd << 7);
      dup_v = 32'h01078033 | 32'((rd + 13) << 7);
      send(ins_v, dup_v, 1'b1);
    end
    tick();
    chk("after_rst_7_orig", {31'b0, bus.in_ready}, 32'd1);
    send(32'h00310433, 32'h01078AB3, 1'b1);
    wait_empty();
    chk("sync_after_rst", 32'(sync_cnt), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qed_dup_scheduler.md
Name: qed_dup_scheduler

Overview:
- Sequences the constrained instruction stream (LW, SW, ADD; registers x0..x12; memory base x0 or x25) into the core front end for EDDI-V style QED checking.
- Issues a block of original instructions and stores each one in an internal FIFO.
- Then replays the block as duplicates, remapped to registers x13..x25 and the x25 memory base.
- Pulses a sync marker once every original has its duplicate issued, so the checker can compare the two register halves.

Parameters:
- DEPTH, 8, original instructions per block (FIFO entries, power of 2, ≥2).
- INSN_LEN, 32, instruction width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- qed_enable  in  1  1 = duplication mode, 0 = bypass
- qed_drain  in  1  request early switch to DUP with a partial block
- in_instruction  in  INSN_LEN  constrained instruction from the source
- in_valid  in  1  in_instruction valid
- in_ready  out  1  scheduler accepts in_instruction this cycle
- out_instruction  out  INSN_LEN  instruction to the core
- out_valid  out  1  out_instruction valid
- out_ready  in  1  core accepts out_instruction
- out_is_dup  out  1  out_instruction is a duplicate
- qed_sync  out  1  one-cycle pulse: block fully duplicated
- illegal_insn  out  1  one-cycle pulse: accepted instruction not LW/SW/ADD

Behaviour:
- Reset (async assert, sync release): state=ORIG, FIFO empty, rd/wr pointers 0, count 0. Outputs on reset: out_valid=0, out_instruction=0, out_is_dup=0, qed_sync=0, illegal_insn=0, mode latch=0 (bypass).
- Output stage is a single register. It loads when out_valid==0 or out_ready==1 ("adv"). Latency from input fire to out_valid is 1 cycle.
- Holding rule: out_instruction and out_is_dup are held stable while out_valid && !out_ready.
- Mode latch: qed_enable is sampled only in ORIG with count==0. Changes at any other time are deferred to that point.
- Bypass (mode latch 0):
  - in_ready = adv.
  - Instructions pass through unchanged with out_is_dup=0.
  - FIFO is untouched; qed_sync never fires.
- State ORIG:
  - in_ready = adv && count<DEPTH.
  - On fire: forward the original (out_is_dup=0).
  - If it decodes as LW, SW or ADD, also push it to the FIFO.
  - Otherwise pulse illegal_insn, forward it anyway, do not push.
  - ORIG→DUP when count reaches DEPTH (counting the push this cycle), or when qed_drain==1 && count>0.
- State DUP:
  - in_ready=0.
  - Each adv cycle: pop the FIFO head, remap it, load it into the output stage with out_is_dup=1.
  - Entries are popped in push order.
  - After the last pop (count becomes 0): DUP→ORIG, and qed_sync pulses in the cycle that last duplicate is accepted (out_valid && out_ready).
- Remap rules (register fields; all other bits unchanged):
  - ADD: rd, rs1, rs2 each become field+13, including x0→x13.
  - LW: rd becomes rd+13; rs1 0→25; rs1 25 stays 25.
  - SW: rs2 becomes rs2+13; rs1 0→25; rs1 25 stays 25.
- Boundary conditions:
  - Full FIFO with in_valid in ORIG: in_ready=0 and the state already moves to DUP; no overflow is possible.
  - Empty FIFO never enters DUP; qed_drain with count==0 is ignored.
  - Pointers wrap modulo DEPTH; count runs 0..DEPTH.
  - qed_drain is ignored in DUP.
  - An illegal instruction in the cycle that fills the FIFO still counts as forwarded only (no push).
  - Reset asserted mid-block: all buffered entries are discarded, out_valid drops immediately, and the block resumes in ORIG with an empty FIFO.

Test Plan:
- Bypass, qed_enable=0, out_ready=1, in_instruction=0x003100B3 → out_instruction=0x003100B3 one cycle later, out_is_dup=0, no qed_sync.
- qed_enable=1, DEPTH=8, 8× ADD x1,x2,x3 (0x003100B3) → 8 originals, in_ready=0, then 8× 0x01078733 with out_is_dup=1; qed_sync pulses once with the 8th duplicate; then back to ORIG.
- LW x5,4(x0)=0x00402283 then qed_drain=1 → original, then duplicate 0x004CA903. SW x3,8(x0)=0x00302423 → duplicate 0x010CA423.
- out_ready=0 for 5 cycles during DUP → out_instruction stable, FIFO count unchanged, no qed_sync; order is preserved after release.
- Non-constrained instruction 0x00000013 in ORIG → forwarded, illegal_insn pulse, count unchanged; qed_drain with count==0 → stays in ORIG.
- rst_n low after 3 originals pushed → out_valid=0 asynchronously; after release count=0 and state ORIG, and 8 fresh pushes are needed before DUP.
